// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// alu_iter : iterative ALU (ADD/SUB/AND/OR single-cycle, MUL shift-add,
//            DIVU/REMU restoring division, one step per RUN cycle)
// Revision : 1.0
// ============================================================================
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] data_hi_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REMU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;     // product high half or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier / dividend, shifted out as result forms
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] data_hi_q, data_hi_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    data_d    = data_q;
    data_hi_d = data_hi_q;
    zero_d    = zero_q;
    err_d     = err_q;

    mul_sum   = {1'b0, hi_q} + {1'b0, opb_q};
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};

    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          if (lo_q[0]) {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end else begin
          // Restoring step: keep the trial difference only if it did not borrow
          if (!div_trial[WIDTH]) begin
            hi_d = div_trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == CW'(1)) begin
          state_d   = S_DONE;
          err_d     = 1'b0;
          data_hi_d = (op_q == OP_MUL) ? hi_d : '0;
          data_d    = (op_q == OP_REMU) ? hi_d : lo_d;
          zero_d    = (data_d == '0);
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start_i) begin
          op_d      = ALUCtrl_i;
          state_d   = S_DONE;
          data_hi_d = '0;
          err_d     = 1'b0;
          case (ALUCtrl_i)
            OP_ADD: data_d = data0_i + data1_i;
            OP_SUB: data_d = data0_i - data1_i;
            OP_AND: data_d = data0_i & data1_i;
            OP_OR:  data_d = data0_i | data1_i;
            OP_MUL: begin
              state_d = S_RUN;
              cnt_d   = CW'(WIDTH);
              hi_d    = '0;
              lo_d    = data0_i;
              opb_d   = data1_i;
            end
            OP_DIVU, OP_REMU: begin
              if (data1_i == '0) begin
                data_d = (ALUCtrl_i == OP_DIVU) ? '1 : data0_i;
                err_d  = 1'b1;
              end else begin
                state_d = S_RUN;
                cnt_d   = CW'(WIDTH);
                hi_d    = '0;
                lo_d    = data0_i;
                opb_d   = data1_i;
              end
            end
            default: begin
              data_d = '0;
              err_d  = 1'b1;
            end
          endcase
          // Multi-cycle ops keep the previous result visible until they finish
          if (state_d == S_DONE) zero_d = (data_d == '0);
          else begin
            data_d    = data_q;
            data_hi_d = data_hi_q;
            err_d     = err_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      data_hi_q <= '0;
      zero_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      data_hi_q <= data_hi_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
    end
  end

  assign ready_o   = (state_q != S_RUN);
  assign valid_o   = (state_q == S_DONE);
  assign data_o    = data_q;
  assign data_hi_o = data_hi_q;
  assign zero_o    = zero_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// tb_alu_iter : randomized and directed bench for alu_iter against an
//               arithmetic reference model
// Revision    : 1.0
// ============================================================================
module tb_alu_iter;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [WIDTH-1:0] data0_i;
  logic [WIDTH-1:0] data1_i;
  logic [2:0]       ALUCtrl_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] data_hi_o;
  logic             zero_o;
  logic             err_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .data0_i   (data0_i),
    .data1_i   (data1_i),
    .ALUCtrl_i (ALUCtrl_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .data_hi_o (data_hi_o),
    .zero_o    (zero_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions of each op.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic [31:0] h,
                       output logic e, output int lat);
    longint unsigned p;
    h = '0; e = 1'b0; lat = 1;
    case (op)
      3'd0: d = a + b;
      3'd1: d = a - b;
      3'd2: begin
        p = longint'(a) * longint'(b);
        d = p[31:0]; h = p[63:32]; lat = WIDTH + 1;
      end
      3'd3: d = a & b;
      3'd4: d = a | b;
      3'd5: if (b == 0) begin d = 32'hFFFF_FFFF; e = 1'b1; end
            else begin d = a / b; lat = WIDTH + 1; end
      3'd6: if (b == 0) begin d = a; e = 1'b1; end
            else begin d = a % b; lat = WIDTH + 1; end
      default: begin d = '0; e = 1'b1; end
    endcase
  endtask

  // Issues one request, waits for valid_o (bounded) and checks everything.
  // Leaves the bench inside the DONE cycle so a following call is back-to-back.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit toggle);
    logic [31:0] ed, eh;
    logic        ee;
    int          elat, lat, rdy_low;
    model(op, a, b, ed, eh, ee, elat);
    start_i = 1'b1; ALUCtrl_i = op; data0_i = a; data1_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = 1; rdy_low = 0;
    while (!valid_o && lat < 100) begin
      if (!ready_o) rdy_low++;
      if (toggle) begin
        start_i = 1'($urandom); data0_i = $urandom; data1_i = $urandom;
        ALUCtrl_i = 3'($urandom);
      end
      @(posedge clk_i); #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, ".lat"},   64'(lat), 64'(elat));
    check({tag, ".rdylo"}, 64'(rdy_low), 64'(elat - 1));
    check({tag, ".data"},  64'(data_o), 64'(ed));
    check({tag, ".hi"},    64'(data_hi_o), 64'(eh));
    check({tag, ".zero"},  64'(zero_o), 64'(ed == 0));
    check({tag, ".err"},   64'(err_o), 64'(ee));
    check({tag, ".ready"}, 64'(ready_o), 64'd1);
  endtask

  // One idle edge: the valid pulse must end and the result must hold.
  task automatic idle_hold(input string tag);
    logic [31:0] d;
    logic        z, e;
    d = data_o; z = zero_o; e = err_o;
    @(posedge clk_i); #1;
    check({tag, ".vdrop"}, 64'(valid_o), 64'd0);
    check({tag, ".dhold"}, 64'(data_o), 64'(d));
    check({tag, ".zhold"}, 64'({zero_o, err_o}), 64'({z, e}));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".valid"}, 64'(valid_o), 64'd0);
    check({tag, ".ready"}, 64'(ready_o), 64'd1);
    check({tag, ".data"},  64'(data_o), 64'd0);
    check({tag, ".hi"},    64'(data_hi_o), 64'd0);
    check({tag, ".zero"},  64'(zero_o), 64'd1);
    check({tag, ".err"},   64'(err_o), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_i = 1'b1; start_i = 1'b0; ALUCtrl_i = '0; data0_i = '0; data1_i = '0;
    #12;
    check_reset_vals("rst");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    do_op("add7_5", 3'd0, 32'd7, 32'd5, 1'b0);
    do_op("sub5_5", 3'd1, 32'd5, 32'd5, 1'b0);
    idle_hold("sub_hold");
    do_op("mul_ff", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    idle_hold("mul_hold");
    do_op("divu", 3'd5, 32'd100, 32'd7, 1'b0);
    do_op("remu", 3'd6, 32'd100, 32'd7, 1'b0);
    do_op("divu_1", 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op("divu_z", 3'd5, 32'd9, 32'd0, 1'b0);
    do_op("remu_z", 3'd6, 32'd9, 32'd0, 1'b0);
    do_op("inval", 3'd7, 32'd3, 32'd4, 1'b0);
    do_op("add1_1", 3'd0, 32'd1, 32'd1, 1'b0);
    do_op("or", 3'd4, 32'h00F0, 32'h0F00, 1'b0);
    do_op("mul_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("div_big", 3'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    idle_hold("div_hold");

    // Asynchronous reset in the middle of a MUL, between clock edges
    start_i = 1'b1; ALUCtrl_i = 3'd2; data0_i = 32'h1234_5678; data1_i = 32'h9ABC_DEF0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1 check_reset_vals("midrst");
    #1 rst_i = 1'b0;
    do_op("and_after_rst", 3'd3, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    idle_hold("and_hold");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      do_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_hold($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
